// File: rtl/jal_fetch_sequencer.sv
// jal_fetch_sequencer: multi-cycle fetch/decode sequencer for the single-issue core.
// Owns the PC and fetches one instruction word at a time. JAL is resolved locally:
// the link value is written and the PC is redirected. Every other instruction is
// offered to the downstream decoders over a valid/ready handshake.
module jal_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_word,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc,
  output logic        halt,
  output logic        misalign
);

  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    LINK,
    HALT
  } state_t;

  state_t      state;
  logic [31:0] ir;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        is_jal;
  logic        rd_nonzero;

  // J-type immediate: scattered fields reassembled and sign-extended, bit 0 always zero.
  function automatic logic [31:0] jal_offset(input logic [31:0] word);
    return {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
  endfunction

  // The fetch address is always the architectural PC.
  assign imem_addr  = pc;
  assign pc_plus4   = pc + 32'd4;
  assign target     = pc + jal_offset(ir);
  assign is_jal     = (ir[6:0] == OP_JAL);
  assign rd_nonzero = (ir[11:7] != 5'd0);

  // Sequencer FSM; every output is registered and set on entry to the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      inst_word  <= '0;
      inst_pc    <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      halt       <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end

        // run is not sampled here: a started fetch always completes.
        FETCH: begin
          if (imem_valid) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= DECODE;
          end
        end

        DECODE: begin
          if (is_jal) begin
            if (target[1]) begin
              state    <= HALT;
              halt     <= 1'b1;
              misalign <= 1'b1;
            end else begin
              state    <= LINK;
              rf_we    <= rd_nonzero;
              rf_waddr <= ir[11:7];
              // Keep the write data at zero when no write is performed.
              rf_wdata <= rd_nonzero ? pc_plus4 : 32'd0;
            end
          end else begin
            state      <= ISSUE;
            inst_valid <= 1'b1;
            inst_word  <= ir;
            inst_pc    <= pc;
          end
        end

        ISSUE: begin
          if (inst_ready) begin
            pc         <= pc_plus4;
            inst_valid <= 1'b0;
            inst_word  <= '0;
            inst_pc    <= '0;
            if (run) begin
              state    <= FETCH;
              imem_req <= 1'b1;
            end else begin
              state    <= IDLE;
            end
          end
        end

        LINK: begin
          pc       <= target;
          rf_we    <= 1'b0;
          rf_waddr <= '0;
          rf_wdata <= '0;
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end else begin
            state    <= IDLE;
          end
        end

        // Terminal: only reset leaves HALT.
        HALT: begin
          state <= HALT;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jal_fetch_sequencer.sv
// Self-checking bench for jal_fetch_sequencer: directed vector table, hand-written
// reset/halt/run-drop sequences, and randomized instruction streams checked against
// an arithmetic reference model of JAL/non-JAL sequencing.
module tb_jal_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int KIND_ISSUE = 0;
  localparam int KIND_LINK  = 1;
  localparam int KIND_HALT  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_word;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pc;
  logic        halt;
  logic        misalign;

  always #5 clk = ~clk;

  jal_fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_word  (inst_word),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .pc         (pc),
    .halt       (halt),
    .misalign   (misalign)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] mpc;

  typedef struct {
    logic        reset_first;
    logic [31:0] word;
    int          mem_wait;
    int          ready_wait;
    int          kind;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc_after;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference JAL offset built from the immediate's weighted fields.
  function automatic logic [31:0] ref_offset(input logic [31:0] w);
    logic [31:0] v;
    v = ((w >> 21) & 32'h3FF) * 32'd2
      + ((w >> 20) & 32'h1) * 32'd2048
      + ((w >> 12) & 32'hFF) * 32'd4096;
    if (w[31]) v = v - 32'h0010_0000;
    return v;
  endfunction

  task automatic check_quiescent(input string tag, input logic [31:0] exp_pc);
    chk({tag, "_imem_req"}, imem_req, 0);
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_imem_addr"}, imem_addr, exp_pc);
    chk({tag, "_inst_valid"}, inst_valid, 0);
    chk({tag, "_inst_word"}, inst_word, 0);
    chk({tag, "_inst_pc"}, inst_pc, 0);
    chk({tag, "_rf_we"}, rf_we, 0);
    chk({tag, "_rf_waddr"}, rf_waddr, 0);
    chk({tag, "_rf_wdata"}, rf_wdata, 0);
    chk({tag, "_halt"}, halt, 0);
    chk({tag, "_misalign"}, misalign, 0);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    run        = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    inst_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    mpc   = RESET_PC;
    tick();
    check_quiescent("reset", RESET_PC);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // Drives one instruction through fetch and checks the resulting behaviour.
  task automatic do_instr(input logic [31:0] word, input int mem_wait, input int ready_wait,
                          input bit drop_run, input int kind, input logic [4:0] e_waddr,
                          input logic [31:0] e_wdata, input logic [31:0] e_pc_after);
    bit ok;
    wait_req(ok);
    if (!ok) begin
      chk("fetch_req_timeout", {31'd0, imem_req}, 1);
      return;
    end
    chk("imem_addr", imem_addr, mpc);
    if (drop_run) run = 1'b0;
    for (int i = 0; i < mem_wait; i++) begin
      imem_rdata = $urandom;
      tick();
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, mpc);
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    tick();
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    chk("req_drop", imem_req, 0);
    chk("decode_inst_valid", inst_valid, 0);
    chk("decode_rf_we", rf_we, 0);
    tick();
    case (kind)
      KIND_LINK: begin
        chk("rf_we", rf_we, {31'd0, e_waddr != 5'd0});
        chk("rf_waddr", rf_waddr, {27'd0, e_waddr});
        chk("rf_wdata", rf_wdata, e_wdata);
        chk("link_inst_valid", inst_valid, 0);
        tick();
        chk("rf_we_pulse", rf_we, 0);
        chk("rf_wdata_clear", rf_wdata, 0);
      end
      KIND_ISSUE: begin
        for (int i = 0; i <= ready_wait; i++) begin
          chk("inst_valid", inst_valid, 1);
          chk("inst_word", inst_word, word);
          chk("inst_pc", inst_pc, mpc);
          chk("issue_rf_we", rf_we, 0);
          if (i == ready_wait) inst_ready = 1'b1;
          tick();
        end
        inst_ready = 1'b0;
        chk("inst_valid_drop", inst_valid, 0);
        chk("inst_word_zero", inst_word, 0);
        chk("inst_pc_zero", inst_pc, 0);
      end
      default: begin
        for (int i = 0; i < 6; i++) begin
          chk("halt", halt, 1);
          chk("misalign", misalign, 1);
          chk("halt_req", imem_req, 0);
          chk("halt_rf_we", rf_we, 0);
          chk("halt_inst_valid", inst_valid, 0);
          tick();
        end
        return;
      end
    endcase
    chk("pc_after", pc, e_pc_after);
    chk("addr_after", imem_addr, e_pc_after);
    chk("req_after", imem_req, {31'd0, run});
    mpc = e_pc_after;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [31:0] w;
    logic [31:0] tgt;
    logic [4:0]  rd;
    bit          drop;

    tbl[0] = '{1'b1, 32'b00001111110101101110_01101_1101111, 0, 0, KIND_LINK, 5'd13,
               32'h0000_0004, 32'h0006_E8FC};
    tbl[1] = '{1'b0, 32'b11001110010101001111_00100_1101111, 1, 0, KIND_LINK, 5'd4,
               32'h0006_E900, 32'hFFFB_E5E0};
    tbl[2] = '{1'b1, 32'h0080_006F, 0, 0, KIND_LINK, 5'd0, 32'h0, 32'h0000_0008};
    tbl[3] = '{1'b1, 32'h0050_0093, 2, 3, KIND_ISSUE, 5'd0, 32'h0, 32'h0000_0004};

    for (int i = 0; i < 4; i++) begin
      if (tbl[i].reset_first) begin
        do_reset();
        run = 1'b1;
      end
      do_instr(tbl[i].word, tbl[i].mem_wait, tbl[i].ready_wait, 1'b0, tbl[i].kind,
               tbl[i].waddr, tbl[i].wdata, tbl[i].pc_after);
    end

    // Misaligned JAL target: sticky halt, no further requests.
    do_reset();
    run = 1'b1;
    do_instr(32'h0020_006F, 0, 0, 1'b0, KIND_HALT, 5'd0, 32'h0, 32'h0);

    // Reset during a stalled fetch; the late imem_valid must be ignored.
    do_reset();
    run = 1'b1;
    do_instr(tbl[0].word, 0, 0, 1'b0, KIND_LINK, 5'd13, 32'h4, 32'h0006_E8FC);
    wait_req(ok);
    chk("pre_reset_req", {31'd0, imem_req}, 1);
    tick();
    tick();
    chk("stall_req", imem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("async_req_drop", imem_req, 0);
    chk("async_pc", pc, RESET_PC);
    chk("async_addr", imem_addr, RESET_PC);
    imem_valid = 1'b1;
    imem_rdata = 32'h0080_006F;
    run = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_quiescent("late_valid", RESET_PC);
    imem_valid = 1'b0;
    mpc = RESET_PC;
    run = 1'b1;
    do_instr(32'h0010_0093, 0, 0, 1'b0, KIND_ISSUE, 5'd0, 32'h0, RESET_PC + 32'd4);

    // run dropped during fetch: instruction completes, then the block parks.
    do_instr(32'h0020_0113, 1, 1, 1'b1, KIND_ISSUE, 5'd0, 32'h0, mpc + 32'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiescent("park", mpc);
    end
    run = 1'b1;

    // Randomized stream against the reference model.
    do_reset();
    run = 1'b1;
    for (int n = 0; n < 60; n++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        w[6:0] = 7'b1101111;
        w[21]  = 1'b0;
        rd     = w[11:7];
        tgt    = mpc + ref_offset(w);
        drop   = ($urandom_range(0, 7) == 0);
        do_instr(w, $urandom_range(0, 3), 0, drop, KIND_LINK, rd,
                 (rd != 5'd0) ? mpc + 32'd4 : 32'h0, tgt);
      end else begin
        if (w[6:0] == 7'b1101111) w[6:0] = 7'b0010011;
        drop = ($urandom_range(0, 7) == 0);
        do_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), drop, KIND_ISSUE,
                 5'd0, 32'h0, mpc + 32'd4);
      end
      if (drop) begin
        tick();
        check_quiescent("rand_park", mpc);
        run = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
